fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 86 ++++++++
 tb/tb_fetch_unit.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch with 2-entry {pc, inst} buffer and ECALL halt
// Optional fetch_count performance counter enabled by FETCH_PERF_COUNT_EN.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_dout,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        halted
`ifdef FETCH_PERF_COUNT_EN
    ,
    output logic [31:0] fetch_count
`endif
);

    localparam logic [31:0] ECALL = 32'h0000_0073;

    logic [31:0] pc;
    logic [31:0] buf_pc   [2];
    logic [31:0] buf_inst [2];
    logic        rd_ptr;
    logic        wr_ptr;
    logic [1:0]  count;
    logic        halted_q;
    logic        pop;
    logic        push;

    assign imem_addr  = pc;
    assign halted     = halted_q;
    assign inst_valid = (count != 2'd0);
    // Head reads as zero while empty so reset leaves inst/inst_pc at 0.
    assign inst       = inst_valid ? buf_inst[rd_ptr] : 32'h0;
    assign inst_pc    = inst_valid ? buf_pc[rd_ptr]   : 32'h0;

    assign pop  = inst_valid & inst_ready;
    assign push = ~redirect_valid & ~halted_q & ((count != 2'd2) | pop);

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc       <= RESET_PC;
            count    <= 2'd0;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            halted_q <= 1'b0;
        end else if (redirect_valid) begin
            // Flush wins over any pop presented in the same cycle.
            pc       <= {redirect_pc[31:2], 2'b00};
            count    <= 2'd0;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            if (push) begin
                buf_pc[wr_ptr]   <= pc;
                buf_inst[wr_ptr] <= imem_dout;
                wr_ptr           <= ~wr_ptr;
                pc               <= pc + 32'd4;
                if (imem_dout == ECALL) begin
                    halted_q <= 1'b1;
                end
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

`ifdef FETCH_PERF_COUNT_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_count <= 32'h0;
        end else if (push) begin
            fetch_count <= fetch_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NO_ECALL = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imem_addr;
    logic [31:0] imem_dout;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        halted;
`ifdef FETCH_PERF_COUNT_EN
    logic [31:0] fetch_count;
`endif

    logic [31:0] ecall_addr = NO_ECALL;
    logic        use_nop = 1'b0;

    logic [31:0] m_pc;
    logic        m_halt;
    logic [31:0] m_count;
    logic [63:0] q[$];
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a, input logic [31:0] ea,
                                             input logic nop);
        if (a == ea) return 32'h0000_0073;
        if (nop) return 32'h0000_0013;
        return {8'hC3, a[25:2], 2'b11};
    endfunction

    assign imem_dout = mem_word(imem_addr, ecall_addr, use_nop);

    fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_addr      (imem_addr),
        .imem_dout      (imem_dout),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .halted         (halted)
`ifdef FETCH_PERF_COUNT_EN
        ,
        .fetch_count    (fetch_count)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_pc    = RST_PC;
        m_halt  = 1'b0;
        m_count = 32'h0;
    endtask

    // One clock: compare outputs with the model, advance the model, cross the edge.
    task automatic tick();
        logic [63:0] e;
        logic        do_pop;
        logic [31:0] w;
        #1;
        check("inst_valid", 32'(inst_valid), 32'(q.size() > 0));
        check("imem_addr", imem_addr, m_pc);
        check("halted", 32'(halted), 32'(m_halt));
`ifdef FETCH_PERF_COUNT_EN
        check("fetch_count", fetch_count, m_count);
`endif
        if (!reset) begin
            model_reset();
        end else begin
            do_pop = (q.size() > 0) && inst_ready;
            if (do_pop) begin
                e = q[0];
                check("head_pc", inst_pc, e[63:32]);
                check("head_inst", inst, e[31:0]);
            end
            if (redirect_valid) begin
                q.delete();
                m_pc   = {redirect_pc[31:2], 2'b00};
                m_halt = 1'b0;
            end else begin
                if (do_pop) void'(q.pop_front());
                if (!m_halt && q.size() < 2) begin
                    w = mem_word(m_pc, ecall_addr, use_nop);
                    q.push_back({m_pc, w});
                    if (w == 32'h0000_0073) m_halt = 1'b1;
                    m_pc    = m_pc + 32'd4;
                    m_count = m_count + 32'd1;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    initial begin
        reset          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        inst_ready     = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        check("rst_valid", 32'(inst_valid), 32'h0);
        check("rst_inst", inst, 32'h0);
        check("rst_inst_pc", inst_pc, 32'h0);
        check("rst_imem_addr", imem_addr, RST_PC);
        check("rst_halted", 32'(halted), 32'h0);

        // Streaming NOPs from reset release.
        use_nop    = 1'b1;
        reset      = 1'b1;
        inst_ready = 1'b1;
        tick();
        check("s_valid1", 32'(inst_valid), 32'h1);
        check("s_pc0", inst_pc, 32'h0);
        check("s_nop", inst, 32'h0000_0013);
        tick();
        check("s_pc4", inst_pc, 32'h4);
        tick();
        check("s_pc8", inst_pc, 32'h8);
        use_nop = 1'b0;

        // Stall from empty, then drain.
        apply_reset();
        inst_ready = 1'b0;
        repeat (5) tick();
        check("stall_valid", 32'(inst_valid), 32'h1);
        check("stall_pc", inst_pc, 32'h0);
        check("stall_addr", imem_addr, 32'h8);
        inst_ready = 1'b1;
        repeat (4) tick();

        // Redirect while full.
        apply_reset();
        inst_ready = 1'b0;
        repeat (3) tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        inst_ready     = 1'b1;
        tick();
        redirect_valid = 1'b0;
        check("rd_valid", 32'(inst_valid), 32'h0);
        check("rd_addr", imem_addr, 32'h100);
        tick();
        check("rd_pc", inst_pc, 32'h100);

        // ECALL halts fetch; redirect resumes.
        ecall_addr = 32'hC;
        apply_reset();
        inst_ready = 1'b1;
        repeat (4) tick();
        check("ec_inst", inst, 32'h0000_0073);
        check("ec_pc", inst_pc, 32'hC);
        check("ec_halted", 32'(halted), 32'h1);
        check("ec_addr", imem_addr, 32'h10);
        repeat (3) tick();
        check("ec_drained", 32'(inst_valid), 32'h0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        tick();
        redirect_valid = 1'b0;
        check("ec_resume", 32'(halted), 32'h0);
        repeat (3) tick();
        ecall_addr = NO_ECALL;

        // PC wrap, then reset with a full stalled buffer.
        inst_ready     = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        tick();
        check("wrap_addr", imem_addr, 32'h0);
        repeat (2) tick();
        reset          = 1'b0;
        redirect_valid = 1'b1;
        inst_ready     = 1'b1;
        tick();
        reset          = 1'b1;
        redirect_valid = 1'b0;
        check("rst_full_valid", 32'(inst_valid), 32'h0);
        check("rst_full_addr", imem_addr, RST_PC);

`ifdef FETCH_PERF_COUNT_EN
        apply_reset();
        inst_ready = 1'b1;
        repeat (10) tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        tick();
        redirect_valid = 1'b0;
        repeat (3) tick();
        check("count13", fetch_count, 32'd13);
`endif

        // Random traffic.
        ecall_addr = 32'h28;
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            inst_ready     = ($urandom_range(0, 2) != 0);
            redirect_valid = ($urandom_range(0, 15) == 0);
            redirect_pc    = ($urandom_range(0, 1) != 0) ? 32'(4 * $urandom_range(0, 15)) + 32'(2 * $urandom_range(0, 1)) : $urandom;
            reset          = ($urandom_range(0, 63) != 0);
            tick();
        end
        reset          = 1'b1;
        redirect_valid = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
